// File: rtl/xdebounce_edge_if.sv
// ============================================================================
// Module   : xdebounce_edge_if
// Brief    : Raw-input / debounced-output bundle for xdebounce_edge.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface xdebounce_edge_if #(
    parameter int NGW = 8
);
    logic           i_raw;
    logic           o_level;
    logic           o_rise;
    logic           o_fall;
    logic           o_glitch;
    logic [NGW-1:0] o_gcnt;

    // Source side: drives the raw level and observes the conditioned result.
    modport master (
        output i_raw,
        input  o_level,
        input  o_rise,
        input  o_fall,
        input  o_glitch,
        input  o_gcnt
    );

    // Debouncer side.
    modport slave (
        input  i_raw,
        output o_level,
        output o_rise,
        output o_fall,
        output o_glitch,
        output o_gcnt
    );
endinterface

`default_nettype wire

// File: rtl/xdebounce_edge.sv
// ============================================================================
// Module   : xdebounce_edge
// Brief    : Synchronise, debounce and edge-detect a raw asynchronous level.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module xdebounce_edge #(
    parameter int NSYNC = 2,
    parameter int NDB   = 16,
    parameter int NGW   = 8
) (
    input  wire logic         clk,
    input  wire logic         rst,
    xdebounce_edge_if.slave   bus
);

    localparam int                CNT_W   = (NDB > 1) ? $clog2(NDB) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(NDB - 1);
    localparam logic [NGW-1:0]    GCNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_LOW    = 2'd0,
        ST_CHK_HI = 2'd1,
        ST_HIGH   = 2'd2,
        ST_CHK_LO = 2'd3
    } state_t;

    logic [NSYNC-1:0] sync_q;
    logic             s;

    state_t           state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             level_q,  level_d;
    logic             rise_q,   rise_d;
    logic             fall_q,   fall_d;
    logic             glitch_q, glitch_d;
    logic [NGW-1:0]   gcnt_q,   gcnt_d;

    // The chain is the only consumer of the asynchronous input.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[NSYNC-2:0], bus.i_raw};
        end
    end

    assign s = sync_q[NSYNC-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_LOW;
            cnt_q    <= '0;
            level_q  <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            glitch_q <= 1'b0;
            gcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            level_q  <= level_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            glitch_q <= glitch_d;
            gcnt_q   <= gcnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        level_d  = level_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        glitch_d = 1'b0;

        case (state_q)
            ST_LOW: begin
                if (s) begin
                    state_d = ST_CHK_HI;
                    cnt_d   = '0;
                end
            end
            ST_CHK_HI: begin
                if (!s) begin
                    state_d  = ST_LOW;
                    glitch_d = 1'b1;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = ST_HIGH;
                    level_d = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HIGH: begin
                if (!s) begin
                    state_d = ST_CHK_LO;
                    cnt_d   = '0;
                end
            end
            ST_CHK_LO: begin
                if (s) begin
                    state_d  = ST_HIGH;
                    glitch_d = 1'b1;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = ST_LOW;
                    level_d = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_LOW;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase
    end

    // Counter advances on the same edge that registers the glitch pulse.
    always_comb begin
        gcnt_d = gcnt_q;
        if (glitch_d && (gcnt_q != GCNT_MAX)) begin
            gcnt_d = gcnt_q + NGW'(1);
        end
    end

    assign bus.o_level  = level_q;
    assign bus.o_rise   = rise_q;
    assign bus.o_fall   = fall_q;
    assign bus.o_glitch = glitch_q;
    assign bus.o_gcnt   = gcnt_q;

endmodule

`default_nettype wire

// File: tb/tb_xdebounce_edge.sv
// ============================================================================
// Module   : tb_xdebounce_edge
// Brief    : Directed, model-checked bench for xdebounce_edge (two counter widths).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_xdebounce_edge;

    localparam int NSYNC = 2;
    localparam int NDB   = 16;
    localparam int NGW   = 8;
    localparam int NGW2  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic raw = 1'b0;

    always #5 clk = ~clk;

    xdebounce_edge_if #(.NGW(NGW))  bus1 ();
    xdebounce_edge_if #(.NGW(NGW2)) bus2 ();

    assign bus1.i_raw = raw;
    assign bus2.i_raw = raw;

    xdebounce_edge #(.NSYNC(NSYNC), .NDB(NDB), .NGW(NGW)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    xdebounce_edge #(.NSYNC(NSYNC), .NDB(NDB), .NGW(NGW2)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    int checks   = 0;
    int failures = 0;

    // Reference: delayed sample stream plus a count of consecutive samples
    // disagreeing with the accepted level; NDB+1 in a row flips the level.
    logic [NSYNC-1:0] m_sync;
    logic             m_level;
    int               m_run;
    logic             m_rise, m_fall, m_glitch;
    int               m_gcnt, m_gcnt2;
    bit               armed = 0;

    int n_rise, n_fall, n_glitch;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic s;
        if (rst) begin
            m_sync  = '0;
            m_level = 1'b0;
            m_run   = 0;
            m_rise  = 1'b0;
            m_fall  = 1'b0;
            m_glitch = 1'b0;
            m_gcnt  = 0;
            m_gcnt2 = 0;
            armed   = 1;
        end else begin
            s       = m_sync[NSYNC-1];
            m_sync  = {m_sync[NSYNC-2:0], raw};
            m_rise  = 1'b0;
            m_fall  = 1'b0;
            m_glitch = 1'b0;
            if (m_run == 0) begin
                if (s != m_level) m_run = 1;
            end else if (s == m_level) begin
                m_glitch = 1'b1;
                m_run    = 0;
                if (m_gcnt  < (1 << NGW)  - 1) m_gcnt++;
                if (m_gcnt2 < (1 << NGW2) - 1) m_gcnt2++;
            end else begin
                m_run++;
                if (m_run == NDB + 1) begin
                    m_level = s;
                    m_rise  = s;
                    m_fall  = !s;
                    m_run   = 0;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        if (armed) begin
            check("level",   bus1.o_level,  m_level);
            check("rise",    bus1.o_rise,   m_rise);
            check("fall",    bus1.o_fall,   m_fall);
            check("glitch",  bus1.o_glitch, m_glitch);
            check("gcnt",    bus1.o_gcnt,   m_gcnt);
            check("gcnt_w2", bus2.o_gcnt,   m_gcnt2);
        end
        if (bus1.o_rise   === 1'b1) n_rise++;
        if (bus1.o_fall   === 1'b1) n_fall++;
        if (bus1.o_glitch === 1'b1) n_glitch++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_counts();
        n_rise   = 0;
        n_fall   = 0;
        n_glitch = 0;
    endtask

    // Returns the 1-based step index of the first rise (sel=1) or fall (sel=0).
    task automatic run_find(input int maxn, input bit sel, output int at);
        at = 0;
        for (int i = 1; i <= maxn; i++) begin
            step();
            if (at == 0 && (sel ? bus1.o_rise : bus1.o_fall) === 1'b1) at = i;
        end
    endtask

    int at;

    initial begin
        clear_counts();
        rst = 1'b1;
        raw = 1'b0;
        run(2);
        check("rst_level",  bus1.o_level,  0);
        check("rst_rise",   bus1.o_rise,   0);
        check("rst_fall",   bus1.o_fall,   0);
        check("rst_glitch", bus1.o_glitch, 0);
        check("rst_gcnt",   bus1.o_gcnt,   0);

        // Clean rise: accepted on edge NSYNC+NDB+1 = 19.
        rst = 1'b0;
        raw = 1'b1;
        clear_counts();
        run(18);
        check("level_before_19", bus1.o_level, 0);
        step();
        check("rise_at_19",  bus1.o_rise,  1);
        check("level_at_19", bus1.o_level, 1);
        run(5);
        check("A_nrise",   n_rise,   1);
        check("A_nfall",   n_fall,   0);
        check("A_nglitch", n_glitch, 0);

        // Clean fall.
        clear_counts();
        raw = 1'b0;
        run_find(30, 1'b0, at);
        check("fall_latency", at, 19);
        check("B_nfall", n_fall, 1);
        check("B_level", bus1.o_level, 0);
        check("B_gcnt",  bus1.o_gcnt, 0);

        // Short pulse of 10 cycles is rejected.
        clear_counts();
        raw = 1'b1; run(10);
        raw = 1'b0; run(25);
        check("C10_nrise",   n_rise,   0);
        check("C10_nglitch", n_glitch, 1);
        check("C10_gcnt",    bus1.o_gcnt, 1);
        check("C10_level",   bus1.o_level, 0);

        // 16 high samples: one short of the NDB+1 = 17 needed.
        clear_counts();
        raw = 1'b1; run(16);
        raw = 1'b0; run(25);
        check("C16_nrise", n_rise, 0);
        check("C16_gcnt",  bus1.o_gcnt, 2);

        // 17 high samples: accepted, then the following low is accepted too.
        clear_counts();
        raw = 1'b1; run(17);
        raw = 1'b0; run(40);
        check("C17_nrise",   n_rise,   1);
        check("C17_nfall",   n_fall,   1);
        check("C17_nglitch", n_glitch, 0);

        // Bounce burst then settle high.
        clear_counts();
        for (int b = 0; b < 5; b++) begin
            raw = 1'b1; run(3);
            raw = 1'b0; run(3);
        end
        raw = 1'b1;
        run_find(30, 1'b1, at);
        check("bounce_rise_latency", at, 19);
        check("bounce_nglitch", n_glitch, 5);
        check("bounce_nrise",   n_rise,   1);
        check("bounce_gcnt",    bus1.o_gcnt, 7);
        check("gcnt_w2_sat",    bus2.o_gcnt, 3);

        // Reset while counting (cnt=8 in CHK_HI) aborts silently.
        raw = 1'b0; run(25);
        clear_counts();
        raw = 1'b1; run(11);
        rst = 1'b1;
        step();
        check("mid_rst_level",  bus1.o_level,  0);
        check("mid_rst_rise",   bus1.o_rise,   0);
        check("mid_rst_glitch", bus1.o_glitch, 0);
        check("mid_rst_gcnt",   bus1.o_gcnt,   0);
        check("mid_rst_gcnt2",  bus2.o_gcnt,   0);
        check("mid_rst_nrise",  n_rise,   0);
        check("mid_rst_nglt",   n_glitch, 0);

        // Input already high at reset release.
        rst = 1'b0;
        clear_counts();
        run_find(30, 1'b1, at);
        check("post_rst_rise_latency", at, 19);
        check("post_rst_nglitch", n_glitch, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
